// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: drives the instruction memory read port, keeps the byte PC
// and hands {word, PC, valid} to decode, with stall back-pressure and redirect handling.
//
// state | meaning
// BOOT  | first edge after reset release; memory still initialising, no response pending
// RUN   | one request per cycle, previous response presented to decode
// HOLD  | decode stalled; inst_* frozen, in-flight word parked in the skid buffer
module inst_fetch_unit #(
    parameter int              DW       = 32,
    parameter int              AW       = 5,
    parameter int              PCW      = 32,
    parameter logic [PCW-1:0]  RESET_PC = '0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    output logic [AW-1:0]  imem_addr_o,
    output logic           imem_rd_en_o,
    input  logic [DW-1:0]  imem_data_i,
    input  logic           stall_i,
    input  logic           redirect_i,
    input  logic [PCW-1:0] redirect_pc_i,
    output logic [DW-1:0]  inst_o,
    output logic [PCW-1:0] inst_pc_o,
    output logic           inst_valid_o,
    output logic           misalign_o
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [PCW-1:0] req_pc_q, req_pc_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           rd_en_q, rd_en_d;
    logic [DW-1:0]  inst_q, inst_d;
    logic [PCW-1:0] inst_pc_q, inst_pc_d;
    logic           valid_q, valid_d;
    logic           misalign_q, misalign_d;
    logic           skid_vld_q, skid_vld_d;
    logic [DW-1:0]  skid_data_q, skid_data_d;
    logic [PCW-1:0] skid_pc_q, skid_pc_d;
    logic [PCW-1:0] target;

    assign target = {redirect_pc_i[PCW-1:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        addr_d      = addr_q;
        rd_en_d     = rd_en_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        valid_d     = valid_q;
        misalign_d  = 1'b0;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;

        if (redirect_i) begin
            // Whatever is in flight or parked belongs to the squashed path.
            addr_d     = target[AW+1:2];
            rd_en_d    = 1'b1;
            req_pc_d   = target;
            pc_d       = target + PCW'(4);
            valid_d    = 1'b0;
            skid_vld_d = 1'b0;
            misalign_d = |redirect_pc_i[1:0];
            state_d    = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    addr_d   = pc_q[AW+1:2];
                    rd_en_d  = 1'b1;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PCW'(4);
                    state_d  = ST_RUN;
                end
                ST_RUN: begin
                    if (stall_i && valid_q) begin
                        skid_vld_d  = rd_en_q;
                        skid_data_d = imem_data_i;
                        skid_pc_d   = req_pc_q;
                        rd_en_d     = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        if (rd_en_q) begin
                            inst_d    = imem_data_i;
                            inst_pc_d = req_pc_q;
                            valid_d   = 1'b1;
                        end else begin
                            valid_d   = 1'b0;
                        end
                        addr_d   = pc_q[AW+1:2];
                        rd_en_d  = 1'b1;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + PCW'(4);
                    end
                end
                ST_HOLD: begin
                    // Memory returns zero while rd_en is low; only the skid entry is trusted.
                    if (!stall_i) begin
                        if (skid_vld_q) begin
                            inst_d    = skid_data_q;
                            inst_pc_d = skid_pc_q;
                            valid_d   = 1'b1;
                        end else begin
                            valid_d   = 1'b0;
                        end
                        skid_vld_d = 1'b0;
                        addr_d     = pc_q[AW+1:2];
                        rd_en_d    = 1'b1;
                        req_pc_d   = pc_q;
                        pc_d       = pc_q + PCW'(4);
                        state_d    = ST_RUN;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            addr_q      <= addr_d;
            rd_en_q     <= rd_en_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            valid_q     <= valid_d;
            misalign_q  <= misalign_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign imem_addr_o  = addr_q;
    assign imem_rd_en_o = rd_en_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = valid_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: negedge-read memory model plus a scoreboard of the PC/word
// stream that decode should accept (valid && !stall at a posedge).
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [4:0]  imem_addr_o;
    logic        imem_rd_en_o;
    logic [31:0] imem_data_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        misalign_o;

    logic [31:0] mem [32];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(.DW(32), .AW(5), .PCW(32), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rd_en_o  (imem_rd_en_o),
        .imem_data_i   (imem_data_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_valid_o  (inst_valid_o),
        .misalign_o    (misalign_o)
    );

    always @(negedge clk) imem_data_i <= imem_rd_en_o ? mem[imem_addr_o] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_run(input logic [31:0] start, input int n);
        logic [31:0] p;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            p = start + 32'(4 * k);
            exp_q.push_back('{pc: p, data: mem[p[6:2]]});
        end
    endtask

    // Drive one cycle of inputs, score anything decode accepts at the coming edge,
    // then step to just after that edge.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc);
        exp_t e;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        if (inst_valid_o && !st) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("acc_pc", inst_pc_o, e.pc);
                chk("acc_data", inst_o, e.data);
            end
        end
        if (rd) push_run({rpc[31:2], 2'b00}, 40);
        @(posedge clk);
        #1;
        redirect_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i) * 32'h0011_0003;
        rst_i = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_rden", 32'(imem_rd_en_o), 32'd0);
        chk("rst_addr", 32'(imem_addr_o), 32'd0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc", inst_pc_o, 32'h0);
        chk("rst_mis", 32'(misalign_o), 32'd0);

        #3 rst_i = 1'b1;
        push_run(32'h0, 40);
        @(posedge clk);
        #1;
        chk("boot_rden", 32'(imem_rd_en_o), 32'd1);
        chk("boot_addr", 32'(imem_addr_o), 32'd0);
        chk("boot_valid", 32'(inst_valid_o), 32'd0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("first_valid", 32'(inst_valid_o), 32'd1);
        chk("first_pc", inst_pc_o, 32'h0);
        chk("addr1", 32'(imem_addr_o), 32'd1);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("pre_stall_pc", inst_pc_o, 32'h8);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            chk("stall_pc", inst_pc_o, 32'h8);
            chk("stall_rden", 32'(imem_rd_en_o), 32'd0);
            chk("stall_valid", 32'(inst_valid_o), 32'd1);
        end
        cyc(1'b0, 1'b0, 32'h0);
        chk("unstall_pc", inst_pc_o, 32'hC);
        cyc(1'b0, 1'b0, 32'h0);
        chk("pc_10", inst_pc_o, 32'h10);

        cyc(1'b0, 1'b1, 32'h0C);
        chk("bubble", 32'(inst_valid_o), 32'd0);
        chk("redir_addr", 32'(imem_addr_o), 32'd3);
        cyc(1'b0, 1'b0, 32'h0);
        chk("redir_pc", inst_pc_o, 32'hC);
        cyc(1'b0, 1'b0, 32'h0);
        chk("redir_pc2", inst_pc_o, 32'h10);

        cyc(1'b0, 1'b1, 32'h0E);
        chk("mis_pulse", 32'(misalign_o), 32'd1);
        chk("mis_bubble", 32'(inst_valid_o), 32'd0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("mis_clear", 32'(misalign_o), 32'd0);
        chk("mis_pc", inst_pc_o, 32'hC);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);

        cyc(1'b0, 1'b1, 32'h70);
        for (int k = 0; k < 6; k++) begin
            chk("wrap_addr", 32'(imem_addr_o), 32'((28 + k) % 32));
            cyc(1'b0, 1'b0, 32'h0);
        end
        chk("wrap_pc", inst_pc_o, 32'h84);
        chk("wrap_data", inst_o, mem[1]);

        cyc(1'b1, 1'b1, 32'h40);
        chk("rs_valid", 32'(inst_valid_o), 32'd0);
        chk("rs_rden", 32'(imem_rd_en_o), 32'd1);
        chk("rs_addr", 32'(imem_addr_o), 32'd16);
        cyc(1'b1, 1'b0, 32'h0);
        chk("rs_cap", inst_pc_o, 32'h40);
        cyc(1'b1, 1'b0, 32'h0);
        chk("rs_hold_pc", inst_pc_o, 32'h40);
        chk("rs_hold_rden", 32'(imem_rd_en_o), 32'd0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h20);
        chk("hold_redir_valid", 32'(inst_valid_o), 32'd0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("hold_redir_pc", inst_pc_o, 32'h20);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);

        #2 rst_i = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid_o), 32'd0);
        chk("arst_rden", 32'(imem_rd_en_o), 32'd0);
        chk("arst_addr", 32'(imem_addr_o), 32'd0);
        chk("arst_inst", inst_o, 32'h0);
        chk("arst_pc", inst_pc_o, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("arst_hold", 32'(imem_rd_en_o), 32'd0);
        #2 rst_i = 1'b1;
        push_run(32'h0, 40);
        @(posedge clk);
        #1;
        chk("reboot_rden", 32'(imem_rd_en_o), 32'd1);
        chk("reboot_valid", 32'(inst_valid_o), 32'd0);
        repeat (4) cyc(1'b0, 1'b0, 32'h0);
        chk("reboot_pc", inst_pc_o, 32'hC);
        chk("reboot_data", inst_o, mem[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
